// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
// Shares one single-port memory bus between instruction fetch (I) and the
// M-stage data port (D). Only one transaction is in flight at a time, and its
// owner stays locked from request to response. D wins arbitration because it
// belongs to the older instruction. A branch flush of an in-flight fetch lets
// the bus transaction finish, but throws its response away.
//
// Optional feature: define CORE_ARB_STARVE_GUARD_EN to build the fetch
// starvation guard. After STARVE_MAX consecutive fetch losses, fetch is
// forced to win. With the macro undefined, D priority is strict and no
// counter is built.
module core_mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_flush,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_wen,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t      r_state;
  logic        r_owner;
  logic        r_drop;

  logic        w_rsp_evt;
  logic        w_arb;
  logic        w_own_i;
  logic        w_flush_hit;
  logic        w_force_i;
  logic        w_d_win;
  logic        w_i_win;
  logic        w_win;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_sel_wen;
  logic [3:0]  w_sel_be;

  // A response only counts while waiting for one; stray rvalid elsewhere is ignored
  assign w_rsp_evt   = (r_state == ST_RSP) & mem_rvalid;
  // Arbitrate when the bus is free or is freed by this cycle's response
  assign w_arb       = (r_state == ST_IDLE) | w_rsp_evt;
  assign w_own_i     = (r_owner == OWN_I);
  assign w_flush_hit = i_flush & w_own_i & ((r_state == ST_REQ) | (r_state == ST_RSP));

`ifdef CORE_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] r_starve_cnt;

  assign w_force_i = i_req & (r_starve_cnt == CW'(STARVE_MAX));

  // Count back-to-back fetch losses; a fetch win or an idle fetch port clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= {CW{1'b0}};
    end else if (w_arb) begin
      if (i_req & w_d_win) begin
        r_starve_cnt <= r_starve_cnt + CW'(1);
      end else begin
        r_starve_cnt <= {CW{1'b0}};
      end
    end
  end
`else
  assign w_force_i = 1'b0;
`endif

  // Pick the winner and select its request fields; fetch is always a full-word read
  always_comb begin
    w_d_win = d_req & ~w_force_i;
    w_i_win = i_req & ~w_d_win;
    w_win   = w_d_win | w_i_win;
    if (w_d_win) begin
      w_sel_addr  = d_addr;
      w_sel_wdata = d_wdata;
      w_sel_wen   = d_wen;
      w_sel_be    = d_be;
    end else begin
      w_sel_addr  = i_addr;
      w_sel_wdata = 32'd0;
      w_sel_wen   = 1'b0;
      w_sel_be    = 4'hF;
    end
  end

  // Grants follow mem_gnt in the same cycle so the requester can release req at once
  assign i_gnt    = mem_gnt & (r_state == ST_REQ) & w_own_i;
  assign d_gnt    = mem_gnt & (r_state == ST_REQ) & (r_owner == OWN_D);
  // A flushed fetch, or a flush arriving in the response cycle, swallows i_rvalid
  assign i_rvalid = w_rsp_evt & w_own_i & ~r_drop & ~i_flush;
  assign d_rvalid = w_rsp_evt & (r_owner == OWN_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

  // Transaction FSM: arbitration, bus output registers, ownership and flush tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWN_I;
      r_drop    <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wen   <= 1'b0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'h0;
    end else if (w_arb) begin
      r_drop <= 1'b0;
      if (w_win) begin
        r_state   <= ST_REQ;
        r_owner   <= w_d_win ? OWN_D : OWN_I;
        mem_req   <= 1'b1;
        mem_addr  <= w_sel_addr;
        mem_wen   <= w_sel_wen;
        mem_wdata <= w_sel_wdata;
        mem_be    <= w_sel_be;
      end else begin
        r_state <= ST_IDLE;
        mem_req <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_flush_hit) begin
            r_drop <= 1'b1;
          end
          if (mem_gnt) begin
            mem_req <= 1'b0;
            r_state <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (w_flush_hit) begin
            r_drop <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          mem_req <= 1'b0;
          r_drop  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: directed scenarios plus a random
// phase, all checked against a transaction-level reference model and a
// reference memory image.
module tb_core_mem_arbiter;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_flush, d_req, d_wen;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_wen, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  core_mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [128];
  logic [31:0] bus_mem [128];

  // bus responder state
  int          gnt_delay, rsp_delay, g_cnt, r_cnt;
  bit          bus_busy, rnd_mode, stray;
  logic [31:0] b_addr, b_wdata;
  logic        b_wen;
  logic [3:0]  b_be;

  // transaction-level reference model
  bit          m_busy, m_acc, m_own, m_drop, m_wen;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
`ifdef CORE_ARB_STARVE_GUARD_EN
  int          m_starve;
`endif

  // snapshot of outputs at the sampling point of the last cycle
  logic        o_i_gnt, o_d_gnt, o_i_rvalid, o_d_rvalid, o_mem_req, o_mem_wen;
  logic [31:0] o_mem_addr, o_i_rdata, o_d_rdata;
  logic [3:0]  o_mem_be;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_acc = 1'b0; m_own = 1'b0; m_drop = 1'b0; m_wen = 1'b0;
    m_addr = 32'd0; m_wdata = 32'd0; m_be = 4'h0;
`ifdef CORE_ARB_STARVE_GUARD_EN
    m_starve = 0;
`endif
    bus_busy = 1'b0; g_cnt = -1; r_cnt = 0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  // One clock cycle: drive bus, sample and compare, advance model and responder
  task automatic cyc();
    logic resp_drv, exp_req, resp, exp_ir, exp_dr, iw;
    mem_gnt  = 1'b0;
    resp_drv = 1'b0;
    if (bus_busy) begin
      if (r_cnt == 0) resp_drv = 1'b1;
      else r_cnt--;
    end else if (mem_req) begin
      if (g_cnt < 0) g_cnt = gnt_delay;
      if (g_cnt == 0) begin mem_gnt = 1'b1; g_cnt = -1; end
      else g_cnt--;
    end
    mem_rvalid = resp_drv | stray;
    mem_rdata  = (resp_drv && !b_wen) ? bus_mem[b_addr[8:2]] : $urandom;
    #1;
    o_i_gnt = i_gnt; o_d_gnt = d_gnt; o_i_rvalid = i_rvalid; o_d_rvalid = d_rvalid;
    o_mem_req = mem_req; o_mem_wen = mem_wen; o_mem_addr = mem_addr; o_mem_be = mem_be;
    o_i_rdata = i_rdata; o_d_rdata = d_rdata;

    exp_req = m_busy && !m_acc;
    check("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
    if (exp_req) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_wen", {31'd0, mem_wen}, {31'd0, m_wen});
      check("mem_be", {28'd0, mem_be}, {28'd0, m_be});
      if (m_wen) check("mem_wdata", mem_wdata, m_wdata);
    end
    check("i_gnt", {31'd0, i_gnt}, {31'd0, exp_req && mem_gnt && !m_own});
    check("d_gnt", {31'd0, d_gnt}, {31'd0, exp_req && mem_gnt && m_own});
    resp   = m_busy && m_acc && mem_rvalid;
    exp_ir = resp && !m_own && !m_drop && !i_flush;
    exp_dr = resp && m_own;
    check("i_rvalid", {31'd0, i_rvalid}, {31'd0, exp_ir});
    check("d_rvalid", {31'd0, d_rvalid}, {31'd0, exp_dr});
    if (exp_ir) check("i_rdata", i_rdata, ref_mem[m_addr[8:2]]);
    if (exp_dr && !m_wen) check("d_rdata", d_rdata, ref_mem[m_addr[8:2]]);
    if (resp && m_wen) ref_mem[m_addr[8:2]] = merge(ref_mem[m_addr[8:2]], m_wdata, m_be);

    if (!m_busy || resp) begin
`ifdef CORE_ARB_STARVE_GUARD_EN
      iw = i_req && (!d_req || m_starve == STARVE_MAX);
      m_starve = (i_req && d_req && !iw) ? m_starve + 1 : 0;
`else
      iw = i_req && !d_req;
`endif
      m_acc = 1'b0; m_drop = 1'b0;
      if (iw) begin
        m_busy = 1'b1; m_own = 1'b0; m_addr = i_addr; m_wen = 1'b0; m_be = 4'hF;
      end else if (d_req) begin
        m_busy = 1'b1; m_own = 1'b1; m_addr = d_addr; m_wen = d_wen;
        m_wdata = d_wdata; m_be = d_be;
      end else begin
        m_busy = 1'b0;
      end
    end else begin
      if (exp_req && mem_gnt) m_acc = 1'b1;
      if (!m_own && i_flush) m_drop = 1'b1;
    end

    if (mem_gnt && mem_req) begin
      bus_busy = 1'b1; b_addr = mem_addr; b_wen = mem_wen; b_wdata = mem_wdata; b_be = mem_be;
      r_cnt = rnd_mode ? int'($urandom_range(0, 3)) : rsp_delay;
      if (rnd_mode) gnt_delay = int'($urandom_range(0, 3));
    end
    if (resp_drv) begin
      if (b_wen) bus_mem[b_addr[8:2]] = merge(bus_mem[b_addr[8:2]], b_wdata, b_be);
      bus_busy = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_w, got_w;
    int ng, nr, gcyc, dg, nmis;
    bit ig_seen, got;

    for (int k = 0; k < 128; k++) begin
      ref_mem[k] = 32'h1000_0000 + 32'(k) * 32'h0101_0101;
    end
    ref_mem[64] = 32'h0000_0013;
    for (int k = 0; k < 128; k++) bus_mem[k] = ref_mem[k];

    rst = 1'b1; i_req = 1'b0; i_addr = 32'd0; i_flush = 1'b0;
    d_req = 1'b0; d_addr = 32'd0; d_wen = 1'b0; d_wdata = 32'd0; d_be = 4'h0;
    rnd_mode = 1'b0; stray = 1'b0; gnt_delay = 0; rsp_delay = 0;
    model_reset();
    mem_rdata = 32'd0;

    // reset state
    @(posedge clk); @(posedge clk); #1;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_1234; i_req = 1'b1; d_req = 1'b1;
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wen_be", {27'd0, mem_wen, mem_be}, 32'd0);
    check("rst_gnts", {30'd0, i_gnt, d_gnt}, 32'd0);
    check("rst_rvalids", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    check("rst_i_rdata_pass", i_rdata, 32'h5A5A_1234);
    check("rst_d_rdata_pass", d_rdata, 32'h5A5A_1234);
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // single fetch with minimum latency; stray rvalid in the gnt cycle is ignored
    i_req = 1'b1; i_addr = 32'h100;
    cyc();
    check("t1_c0_mem_req", {31'd0, o_mem_req}, 32'd0);
    stray = 1'b1;
    cyc();
    stray = 1'b0;
    check("t1_c1_mem_req", {31'd0, o_mem_req}, 32'd1);
    check("t1_c1_mem_addr", o_mem_addr, 32'h100);
    check("t1_c1_mem_be", {28'd0, o_mem_be}, 32'hF);
    check("t1_c1_i_gnt", {31'd0, o_i_gnt}, 32'd1);
    i_req = 1'b0;
    cyc();
    check("t1_c2_i_rvalid", {31'd0, o_i_rvalid}, 32'd1);
    check("t1_c2_i_rdata", o_i_rdata, 32'h13);
    stray = 1'b1;
    cyc();
    stray = 1'b0;
    check("t1_idle_stray_rvalid", {30'd0, o_i_rvalid, o_d_rvalid}, 32'd0);

    // contention: D store first, fetch follows without an idle bubble
    i_req = 1'b1; i_addr = 32'h104;
    d_req = 1'b1; d_addr = 32'h2004; d_wen = 1'b1; d_wdata = 32'hDEAD_BEEF; d_be = 4'b1100;
    cyc();
    cyc();
    check("t2_c1_d_gnt", {31'd0, o_d_gnt}, 32'd1);
    check("t2_c1_i_gnt", {31'd0, o_i_gnt}, 32'd0);
    check("t2_c1_mem_wen", {31'd0, o_mem_wen}, 32'd1);
    check("t2_c1_mem_be", {28'd0, o_mem_be}, 32'hC);
    check("t2_c1_mem_addr", o_mem_addr, 32'h2004);
    d_req = 1'b0; d_wen = 1'b0;
    cyc();
    check("t2_c2_d_rvalid", {31'd0, o_d_rvalid}, 32'd1);
    cyc();
    check("t2_c3_mem_req", {31'd0, o_mem_req}, 32'd1);
    check("t2_c3_mem_addr", o_mem_addr, 32'h104);
    check("t2_c3_i_gnt", {31'd0, o_i_gnt}, 32'd1);
    i_req = 1'b0;
    cyc();
    check("t2_c4_i_rvalid", {31'd0, o_i_rvalid}, 32'd1);
    check("t2_c4_i_rdata", o_i_rdata, 32'h1000_0000 + 32'd65 * 32'h0101_0101);

    // flush in RSP drops the fetch response; next D load is served normally
    i_req = 1'b1; i_addr = 32'h108; rsp_delay = 3;
    cyc();
    cyc();
    check("t3_i_gnt", {31'd0, o_i_gnt}, 32'd1);
    i_req = 1'b0; i_flush = 1'b1;
    cyc();
    i_flush = 1'b0;
    check("t3_c2_i_rvalid", {31'd0, o_i_rvalid}, 32'd0);
    cyc();
    check("t3_c3_i_rvalid", {31'd0, o_i_rvalid}, 32'd0);
    cyc();
    check("t3_c4_i_rvalid", {31'd0, o_i_rvalid}, 32'd0);
    d_req = 1'b1; d_addr = 32'h2004; d_wen = 1'b0; rsp_delay = 0;
    cyc();
    check("t3_c5_i_rvalid", {31'd0, o_i_rvalid}, 32'd0);
    cyc();
    check("t3_c6_d_gnt", {31'd0, o_d_gnt}, 32'd1);
    d_req = 1'b0;
    cyc();
    exp_w = merge(32'h1000_0000 + 32'd1 * 32'h0101_0101, 32'hDEAD_BEEF, 4'b1100);
    check("t3_c7_d_rvalid", {31'd0, o_d_rvalid}, 32'd1);
    check("t3_c7_d_rdata", o_d_rdata, exp_w);

    // flush exactly in the rvalid cycle
    i_req = 1'b1; i_addr = 32'h10C;
    cyc();
    cyc();
    i_req = 1'b0; i_flush = 1'b1;
    cyc();
    i_flush = 1'b0;
    check("t3b_flush_in_rvalid", {31'd0, o_i_rvalid}, 32'd0);
    cyc();

    // bus wait states
    gnt_delay = 5; rsp_delay = 1; ng = 0; nr = 0; gcyc = -1;
    i_req = 1'b1; i_addr = 32'h110;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (o_i_gnt) begin ng++; gcyc = k; i_req = 1'b0; end
      if (o_i_rvalid) nr++;
    end
    check("t4_gnt_count", 32'(ng), 32'd1);
    check("t4_rvalid_count", 32'(nr), 32'd1);
    check("t4_gnt_cycle", 32'(gcyc), 32'd6);
    gnt_delay = 0;

    // asynchronous reset while waiting for a response
    rsp_delay = 4; i_req = 1'b1; i_addr = 32'h114;
    cyc();
    cyc();
    i_req = 1'b0;
    cyc();
    #3;
    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    rst = 1'b1;
    #1;
    check("t5_rst_mem_addr", mem_addr, 32'd0);
    check("t5_rst_mem_req_be", {27'd0, mem_req, mem_be}, 32'd0);
    check("t5_rst_outs", {28'd0, i_gnt, d_gnt, i_rvalid, d_rvalid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    rsp_delay = 0; got = 1'b0; got_w = 32'd0;
    d_req = 1'b1; d_addr = 32'h2004; d_wen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (o_d_gnt) d_req = 1'b0;
      if (o_d_rvalid) begin got = 1'b1; got_w = o_d_rdata; end
    end
    check("t5_post_rst_done", {31'd0, got}, 32'd1);
    check("t5_post_rst_data", got_w, exp_w);

    // starvation: D held high back-to-back, fetch pending
    dg = 0; ig_seen = 1'b0;
    d_req = 1'b1; d_addr = 32'h2008; d_wen = 1'b1; d_wdata = 32'h0BAD_F00D; d_be = 4'hF;
    i_req = 1'b1; i_addr = 32'h118;
    for (int k = 0; k < 40 && !ig_seen && dg < 8; k++) begin
      cyc();
      if (o_d_gnt) dg++;
      if (o_i_gnt) begin ig_seen = 1'b1; i_req = 1'b0; end
    end
`ifdef CORE_ARB_STARVE_GUARD_EN
    check("t6_d_wins_before_i", 32'(dg), 32'(STARVE_MAX));
    check("t6_i_granted", {31'd0, ig_seen}, 32'd1);
`else
    check("t6_d_wins", 32'(dg), 32'd8);
    check("t6_i_never_granted", {31'd0, ig_seen}, 32'd0);
`endif
    d_req = 1'b0; d_wen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (o_i_gnt) i_req = 1'b0;
    end
    i_req = 1'b0;

    // random phase
    rnd_mode = 1'b1;
    for (int k = 0; k < 600; k++) begin
      i_flush = ($urandom_range(0, 7) == 0);
      cyc();
      if (o_i_gnt) i_req = 1'b0;
      if (o_d_gnt) d_req = 1'b0;
      if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1; i_addr = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_addr = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
        d_wen = 1'($urandom_range(0, 1)); d_wdata = $urandom; d_be = 4'($urandom_range(0, 15));
      end
    end
    i_flush = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (o_i_gnt) i_req = 1'b0;
      if (o_d_gnt) d_req = 1'b0;
    end
    i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 10; k++) cyc();
    nmis = 0;
    for (int k = 0; k < 128; k++) if (bus_mem[k] !== ref_mem[k]) nmis++;
    check("final_mem_image", 32'(nmis), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares one single-port memory bus between instruction fetch (I) and the M-stage data port (D) of the 5-stage core.
- Allows one outstanding transaction; the owner is locked from request to response.
- Data has priority because it belongs to the older instruction; an optional starvation guard protects fetch.
- Handles branch flush of an in-flight fetch by discarding its response.

Parameters:
- STARVE_MAX, 4: consecutive fetch losses before fetch is forced to win (used only with the optional feature).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- i_req  in  1  fetch request; held until i_gnt
- i_addr  in  32  fetch address, word aligned
- i_flush  in  1  branch flush; kills the in-flight fetch
- i_gnt  out  1  fetch request accepted by memory
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  32  fetch read data
- d_req  in  1  data request; held until d_gnt
- d_addr  in  32  data address
- d_wen  in  1  1 = store, 0 = load
- d_wdata  in  32  store data, lane aligned
- d_be  in  4  byte enables
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  load data / store ack valid
- d_rdata  out  32  load data
- mem_req  out  1  bus request
- mem_addr  out  32  bus address
- mem_wen  out  1  bus write
- mem_wdata  out  32  bus write data
- mem_be  out  4  bus byte enables
- mem_gnt  in  1  bus accepted request
- mem_rvalid  in  1  bus response; one per request, stores included
- mem_rdata  in  32  bus read data

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset: state=IDLE, owner=I, drop=0, starve count=0. All mem_* outputs and all *_gnt/*_rvalid are 0. i_rdata/d_rdata pass mem_rdata through unqualified.
- States:
  - IDLE: no transaction.
  - REQ: request presented; mem_req=1.
  - RSP: waiting for mem_rvalid.
- Arbitration (in IDLE, or in RSP on the mem_rvalid cycle):
  - d_req wins over i_req.
  - On a win, register owner, addr, wen, wdata and be into the mem_* output registers, then go to REQ.
  - Fetch requests always drive wen=0 and be=4'hF.
  - With no request, go to (or stay in) IDLE.
- REQ: mem_* outputs stay stable until mem_gnt.
  - On mem_gnt, pulse the owner's *_gnt combinationally in the same cycle (mem_gnt & state==REQ & owner match), then go to RSP.
  - mem_req drops the cycle after mem_gnt.
- RSP: on mem_rvalid, pulse the owner's *_rvalid for one cycle. Then re-arbitrate as above: back-to-back transactions go RSP->REQ with no IDLE bubble.
- Latency: req seen at cycle 0 in IDLE; mem_req at cycle 1; earliest gnt at cycle 1; earliest rvalid at cycle 2; the next transaction's mem_req at cycle 3.
- Requester rule: it must hold req and its fields stable until its gnt. It may reassert req in the cycle after gnt. Arbitration samples req and fields at the arbitration cycle.
- Flush:
  - i_flush in REQ or RSP with owner=I sets drop.
  - The transaction still completes on the bus, because a request cannot be withdrawn after mem_req.
  - i_gnt still pulses on mem_gnt.
  - i_rvalid is suppressed when drop=1, or when i_flush is high in the rvalid cycle itself.
  - drop clears on leaving RSP.
  - i_flush in IDLE, or with owner=D, has no effect.
- Simultaneous events:
  - d_req and i_req together: D wins.
  - mem_gnt and mem_rvalid together in REQ: mem_rvalid is ignored, since it is illegal on the bus.
  - mem_rvalid in IDLE: ignored, no *_rvalid.
- Reset mid-transaction: immediately IDLE with outputs 0. The memory side must be reset by the same rst.
- busy is not exported; the hazard unit derives stalls from req & !gnt.

Optional Feature:
- Macro: CORE_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter of width $clog2(STARVE_MAX+1) increments each arbitration in which i_req=1 and D wins. It clears when I wins or i_req=0.
  - When the count equals STARVE_MAX, I wins even if d_req=1.
  - The counter resets to 0.
- Undefined: strict D priority; no counter is built.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, mem_gnt at cycle 1, mem_rvalid+rdata=0x00000013 at cycle 2 -> mem_addr=0x100, mem_be=4'hF, i_gnt at cycle 1, i_rvalid with i_rdata=0x13 at cycle 2.
- Contention: i_req and d_req (store, addr 0x2004, wdata 0xDEADBEEF, be 4'b1100) both at cycle 0 -> D served first with mem_wen=1, mem_be=4'b1100. Fetch mem_req follows in the cycle after d_rvalid, with no IDLE bubble.
- Flush: fetch granted, i_flush pulsed in RSP, mem_rvalid 3 cycles later -> no i_rvalid. The next d_req is served normally.
- Bus wait states: mem_gnt delayed 5 cycles -> mem_* stable throughout, exactly one i_gnt, one i_rvalid.
- Reset in RSP: assert rst asynchronously mid-cycle -> all outputs 0 immediately. After release, a fresh d_req completes normally.
- Starvation, with macro defined and STARVE_MAX=4: d_req held high back-to-back, i_req high -> fetch granted at the 5th arbitration. Without the macro, fetch is never granted while d_req=1.
